tdp_ram_param: RTL
==================

TDP_RAM_PARAM -- requirements
Module: tdp_ram_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter RDW_MODE, default READ_FIRST, same-port read-during-write policy (READ_FIRST | WRITE_FIRST).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port init_done  output  1  high once memory clear is complete.
REQ-008 The block SHALL have port ena / enb  input  1  port A / B access enable.
REQ-009 The block SHALL have port wea / web  input  DATA_W/8  per-byte write enables.
REQ-010 The block SHALL have port addra / addrb  input  ADDR_W  word address.
REQ-011 The block SHALL have port dina / dinb  input  DATA_W  write data.
REQ-012 The block SHALL have port douta / doutb  output  DATA_W  registered read data.
REQ-013 The block SHALL have port dvalida / dvalidb  output  1  douta / doutb valid, one-cycle pulse.
REQ-014 The block SHALL have port collision  output  1  one-cycle pulse on a same-address conflict.

Function
REQ-015 The block SHALL use FSM states INIT and READY; reset enters INIT.
REQ-016 In INIT the block SHALL write zero to one word per cycle at addresses 0..DEPTH-1, then go to READY, taking DEPTH cycles.
REQ-017 In INIT the block SHALL ignore ena/enb, hold dvalida/dvalidb and collision low, and hold init_done low; init_done SHALL be high in READY.
REQ-018 In READY, an access with en=1 SHALL write each byte whose we bit is set, and SHALL register a read of addr with latency 1 (dout and dvalid updated at the next edge).
REQ-019 With en=0 the block SHALL hold dout at its last value and drive dvalid low.
REQ-020 A same-port write+read SHALL return the pre-write word if RDW_MODE=READ_FIRST, else the byte-merged new word.
REQ-021 A cross-port read of an address written by the other port in the same cycle SHALL return the pre-write word.
REQ-022 When both ports write the same address in the same cycle, the block SHALL apply port A's value to bytes enabled on both ports and apply each port's value to bytes only it enables.
REQ-023 collision SHALL pulse in the cycle after ena&enb with addra==addrb and at least one nonzero we.
REQ-024 Addresses SHALL be ADDR_W wide with no wrap or range check, since every value is legal.

Reset
REQ-025 Asserting rst_n low at any time, including mid-INIT or mid-access, SHALL immediately drive douta, doutb, dvalida, dvalidb, collision and init_done to 0 and reset the FSM to INIT with the clear counter at 0.
REQ-026 The block SHALL not reset memory contents asynchronously; the clear happens only through INIT after reset release.

Structure
REQ-027 Package tdp_ram_pkg SHALL hold the rdw_mode_e enum (READ_FIRST, WRITE_FIRST) and the state enum (INIT, READY).
REQ-028 The INIT FSM and clear counter SHALL be sub-module tdp_ram_init_ctrl, outputting clr_we, clr_addr and init_done.
REQ-029 The storage array SHALL be a single unpacked array written from one always_ff process.

Verification
REQ-030 The bench SHALL release reset with default params, count cycles until init_done=1 (expect 8), then read all 8 addresses and expect 0x00 each.
REQ-031 The bench SHALL write 0xA5 to A addr 3 and then read B addr 3, expecting doutb=0xA5 and dvalidb=1 one cycle after the read.
REQ-032 With DATA_W=16, the bench SHALL write A 0x1234 wea=11 and B 0xABCD web=10 to addr 2 in the same cycle, then expect collision=1 next cycle and a read of addr 2 returning 0x1234.
REQ-033 With old word 0x11, the bench SHALL write 0x22 on A and read the same address on A, expecting 0x11 for READ_FIRST and 0x22 for WRITE_FIRST; a cross-port read in that cycle SHALL return 0x11.
REQ-034 The bench SHALL assert rst_n low for one cycle at INIT count 4, expecting outputs at 0 immediately and init_done after 8 further cycles.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared types for the true dual-port RAM
package tdp_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/tdp_ram_init_ctrl.sv
// rtl/tdp_ram_init_ctrl.sv - post-reset memory clear sequencer
module tdp_ram_init_ctrl
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_done
);

    state_e            state;
    logic [ADDR_W-1:0] cnt;

    // One word cleared per cycle; the last address hands over to READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == '1) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: init_done <= 1'b1;
            endcase
        end
    end

    assign clr_we   = (state == INIT);
    assign clr_addr = cnt;

endmodule

// File: rtl/tdp_ram_param.sv
// rtl/tdp_ram_param.sv - parameterised true dual-port RAM with byte enables
module tdp_ram_param
    import tdp_ram_pkg::*;
#(
    parameter int        DATA_W   = 8,
    parameter int        ADDR_W   = 3,
    parameter rdw_mode_e RDW_MODE = READ_FIRST
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                dvalida,
    input  logic                enb,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   doutb,
    output logic                dvalidb,
    output logic                collision
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b;

    tdp_ram_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    // Port A is written last so it owns bytes both ports enable.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (enb && web[b]) mem[addrb][b*8 +: 8] <= dinb[b*8 +: 8];
                if (ena && wea[b]) mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
            end
        end
    end

    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    // Own-port byte merge, only used when RDW_MODE is WRITE_FIRST.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int b = 0; b < NB; b++) begin
            if (wea[b]) new_a[b*8 +: 8] = dina[b*8 +: 8];
            if (web[b]) new_b[b*8 +: 8] = dinb[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta     <= '0;
            doutb     <= '0;
            dvalida   <= 1'b0;
            dvalidb   <= 1'b0;
            collision <= 1'b0;
        end else begin
            dvalida   <= init_done && ena;
            dvalidb   <= init_done && enb;
            collision <= init_done && ena && enb && (addra == addrb) && ((|wea) || (|web));
            if (init_done && ena) douta <= (RDW_MODE == WRITE_FIRST) ? new_a : old_a;
            if (init_done && enb) doutb <= (RDW_MODE == WRITE_FIRST) ? new_b : old_b;
        end
    end

endmodule
